// File: rtl/noc_port_arbiter.sv
// Wormhole round-robin arbiter sharing one credit-controlled router input link.
// Locks the link to one requester from head to tail and tracks downstream credits.
module noc_port_arbiter #(
    parameter int NREQ    = 4,
    parameter int DW      = 20,
    parameter int CREDITS = 7,
    localparam int CW     = $clog2(CREDITS + 1),
    localparam int OW     = $clog2(NREQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ*DW-1:0] req_data,
    output logic [NREQ-1:0]    req_ready,
    input  logic               ci,
    output logic [DW-1:0]      dataout,
    output logic               out_valid,
    output logic [CW-1:0]      credits,
    output logic [OW-1:0]      owner,
    output logic               credit_err
);

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t           r_state;
    logic [OW-1:0]    r_rr_ptr;
    logic [OW-1:0]    r_owner;
    logic [CW-1:0]    r_credits;
    logic [DW-1:0]    r_dataout;
    logic             r_out_valid;
    logic             r_credit_err;

    logic [NREQ-1:0]  w_elig;
    logic [NREQ-1:0]  w_ready;
    logic             w_found;
    logic [OW-1:0]    w_win;
    logic [OW-1:0]    w_idx;
    logic [OW-1:0]    w_sel;
    logic [DW-1:0]    w_flit;
    logic [1:0]       w_type;
    logic             w_send;

    // Head (10) and single (11) both have the type MSB set.
    always_comb begin
        w_elig = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_elig[i] = req_valid[i] & req_data[i*DW + DW-1];
        end
    end

    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_idx   = '0;
        for (int k = 1; k <= NREQ; k++) begin
            w_idx = OW'((int'(r_rr_ptr) + k) % NREQ);
            if (!w_found && w_elig[w_idx]) begin
                w_found = 1'b1;
                w_win   = w_idx;
            end
        end
    end

    always_comb begin
        w_ready = '0;
        if (r_credits != '0) begin
            if (r_state == IDLE) begin
                if (w_found) w_ready[w_win] = 1'b1;
            end else begin
                w_ready[r_owner] = 1'b1;
            end
        end
    end

    assign w_sel  = (r_state == IDLE) ? w_win : r_owner;
    assign w_send = |(req_valid & w_ready);

    always_comb begin
        w_flit = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (OW'(i) == w_sel) w_flit = req_data[i*DW +: DW];
        end
    end

    assign w_type = w_flit[DW-1:DW-2];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_rr_ptr     <= OW'(NREQ - 1);
            r_owner      <= '0;
            r_credits    <= CW'(CREDITS);
            r_dataout    <= '0;
            r_out_valid  <= 1'b0;
            r_credit_err <= 1'b0;
        end else begin
            r_out_valid <= w_send;
            if (w_send) r_dataout <= w_flit;

            if (w_send && !ci) begin
                r_credits <= r_credits - CW'(1);
            end else if (!w_send && ci) begin
                if (r_credits == CW'(CREDITS)) r_credit_err <= 1'b1;
                else r_credits <= r_credits + CW'(1);
            end

            if (w_send) begin
                if (r_state == IDLE) begin
                    r_owner  <= w_win;
                    r_rr_ptr <= w_win;
                    if (w_type == 2'b10) r_state <= LOCKED;
                end else if (w_type == 2'b01) begin
                    r_state <= IDLE;
                end
            end
        end
    end

    assign req_ready  = w_ready;
    assign dataout    = r_dataout;
    assign out_valid  = r_out_valid;
    assign credits    = r_credits;
    assign owner      = r_owner;
    assign credit_err = r_credit_err;

endmodule

// File: tb/tb_noc_port_arbiter.sv
// Directed testbench for noc_port_arbiter: fairness, wormhole lock,
// credit starvation/overflow and reset mid-packet.
module tb_noc_port_arbiter;

    localparam int NREQ = 4;
    localparam int DW   = 20;

    logic               clk = 1'b0;
    logic               rst;
    logic [NREQ-1:0]    req_valid;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]    req_ready;
    logic               ci;
    logic [DW-1:0]      dataout;
    logic               out_valid;
    logic [2:0]         credits;
    logic [1:0]         owner;
    logic               credit_err;

    int total = 0;
    int bad   = 0;

    noc_port_arbiter #(.NREQ(NREQ), .DW(DW), .CREDITS(7)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .ci        (ci),
        .dataout   (dataout),
        .out_valid (out_valid),
        .credits   (credits),
        .owner     (owner),
        .credit_err(credit_err)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] flit(input logic [1:0] t, input int pl);
        return {t, 18'(pl)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_lane(input int i, input logic [DW-1:0] f);
        req_data[i*DW +: DW] = f;
    endtask

    initial begin
        rst = 1'b1; req_valid = '0; req_data = '0; ci = 1'b0;
        tick(); tick();
        rst = 1'b0;
        #1;
        chk("rst_dataout", 32'(dataout), 0);
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_credits", 32'(credits), 7);
        chk("rst_owner", 32'(owner), 0);
        chk("rst_err", 32'(credit_err), 0);
        chk("rst_ready", 32'(req_ready), 0);

        // Fairness: all lanes present singles
        for (int i = 0; i < NREQ; i++) set_lane(i, flit(2'b11, i + 1));
        req_valid = 4'b1111;
        for (int n = 0; n < 4; n++) begin
            #1;
            chk($sformatf("rr_ready%0d", n), 32'(req_ready), 32'(1 << n));
            tick();
            chk($sformatf("rr_valid%0d", n), 32'(out_valid), 1);
            chk($sformatf("rr_data%0d", n), 32'(dataout),
                32'(flit(2'b11, n + 1)));
            chk($sformatf("rr_cred%0d", n), 32'(credits), 32'(6 - n));
            chk($sformatf("rr_owner%0d", n), 32'(owner), 32'(n));
        end
        #1;
        chk("rr_wrap", 32'(req_ready), 32'b0001);
        req_valid = '0;
        tick();
        chk("idle_valid", 32'(out_valid), 0);
        chk("idle_hold", 32'(dataout), 32'(flit(2'b11, 4)));
        chk("idle_cred", 32'(credits), 3);

        // Send and ci together, then ci alone
        req_valid = 4'b0001; ci = 1'b1;
        #1;
        chk("sc_ready", 32'(req_ready), 32'b0001);
        tick();
        chk("sc_cred", 32'(credits), 3);
        chk("sc_valid", 32'(out_valid), 1);
        req_valid = '0;
        tick();
        chk("ci_cred", 32'(credits), 4);

        // Wormhole: lane 2 packet while lane 0 holds a head; rr_ptr=0
        set_lane(0, flit(2'b10, 16'h0a0));
        for (int n = 0; n < 5; n++) begin
            logic [1:0] t;
            t = (n == 0) ? 2'b10 : (n == 4) ? 2'b01 : 2'b00;
            set_lane(2, flit(t, 16'h200 + n));
            req_valid = 4'b0101;
            #1;
            chk($sformatf("wh_ready%0d", n), 32'(req_ready), 32'b0100);
            tick();
            chk($sformatf("wh_data%0d", n), 32'(dataout),
                32'(flit(t, 16'h200 + n)));
            chk($sformatf("wh_valid%0d", n), 32'(out_valid), 1);
            chk($sformatf("wh_owner%0d", n), 32'(owner), 2);
        end
        req_valid = 4'b0001;
        #1;
        chk("wh_l0_ready", 32'(req_ready), 32'b0001);
        tick();
        chk("wh_l0_data", 32'(dataout), 32'(flit(2'b10, 16'h0a0)));
        chk("wh_l0_owner", 32'(owner), 0);
        chk("wh_cred", 32'(credits), 4);
        set_lane(0, flit(2'b01, 16'h0a1));
        #1;
        chk("wh_l0_tail_rdy", 32'(req_ready), 32'b0001);
        tick();
        chk("wh_l0_tail", 32'(dataout), 32'(flit(2'b01, 16'h0a1)));
        ci = 1'b0; req_valid = '0;

        // Overflow: credits 4 -> 7, then one more ci
        ci = 1'b1;
        tick(); tick(); tick();
        chk("ov_full", 32'(credits), 7);
        chk("ov_noerr", 32'(credit_err), 0);
        tick();
        ci = 1'b0;
        chk("ov_cred", 32'(credits), 7);
        chk("ov_err", 32'(credit_err), 1);
        tick();
        chk("ov_sticky", 32'(credit_err), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("ov_rst_err", 32'(credit_err), 0);
        chk("ov_rst_cred", 32'(credits), 7);
        chk("ov_rst_valid", 32'(out_valid), 0);
        chk("ov_rst_owner", 32'(owner), 0);

        // Starvation: lane 1 singles, no ci
        set_lane(1, flit(2'b11, 16'h111));
        req_valid = 4'b0010;
        for (int n = 0; n < 7; n++) begin
            #1;
            chk($sformatf("st_ready%0d", n), 32'(req_ready), 32'b0010);
            tick();
        end
        chk("st_cred0", 32'(credits), 0);
        #1;
        chk("st_noready", 32'(req_ready), 0);
        tick();
        chk("st_novalid", 32'(out_valid), 0);
        ci = 1'b1;
        #1;
        chk("st_ci_noready", 32'(req_ready), 0);
        tick();
        ci = 1'b0;
        chk("st_cred1", 32'(credits), 1);
        #1;
        chk("st_resume", 32'(req_ready), 32'b0010);
        tick();
        chk("st_sent", 32'(out_valid), 1);
        chk("st_cred_end", 32'(credits), 0);
        req_valid = '0;
        ci = 1'b1;
        tick(); tick(); tick(); tick();
        ci = 1'b0;
        chk("st_refill", 32'(credits), 4);

        // Reset mid-packet on lane 1
        set_lane(1, flit(2'b10, 16'h150));
        req_valid = 4'b0010;
        tick();
        chk("mp_head_owner", 32'(owner), 1);
        set_lane(1, flit(2'b00, 16'h151));
        tick();
        chk("mp_body", 32'(dataout), 32'(flit(2'b00, 16'h151)));
        set_lane(1, flit(2'b00, 16'h152));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mp_cred", 32'(credits), 7);
        chk("mp_valid", 32'(out_valid), 0);
        #1;
        chk("mp_body_blocked", 32'(req_ready), 0);
        set_lane(1, flit(2'b10, 16'h160));
        #1;
        chk("mp_head_ready", 32'(req_ready), 32'b0010);
        tick();
        chk("mp_head_data", 32'(dataout), 32'(flit(2'b10, 16'h160)));
        chk("mp_owner", 32'(owner), 1);
        req_valid = '0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
